// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store unit: size encodings,
// FSM states, request opcodes and big-endian byte-enable bases.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

  // Enables for offset 0; shifted right by the byte offset (bit3 = MSB lane).
  localparam logic [3:0] BE_BYTE = 4'b1000;
  localparam logic [3:0] BE_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Encoding 3 is folded into a word access.
  function automatic size_e norm_size(input logic [1:0] sz);
    size_e res;
    case (sz)
      2'd0:    res = SZ_BYTE;
      2'd1:    res = SZ_HALF;
      default: res = SZ_WORD;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] size_bytes(input size_e sz);
    logic [2:0] res;
    case (sz)
      SZ_BYTE: res = 3'd1;
      SZ_HALF: res = 3'd2;
      default: res = 3'd4;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Combinational big-endian lane select with sign/zero extension for loads.
// Kept standalone so a cache refill path can share it.
module load_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can leave it unassigned (latch).
  always_comb begin
    byte_lane = rdata_i[31:24];
    half_lane = rdata_i[31:16];
    data_o    = rdata_i;

    case (off_i)
      2'd0:    byte_lane = rdata_i[31:24];
      2'd1:    byte_lane = rdata_i[23:16];
      2'd2:    byte_lane = rdata_i[15:8];
      default: byte_lane = rdata_i[7:0];
    endcase

    if (off_i[1]) half_lane = rdata_i[15:0];

    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
      SZ_HALF: data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX-stage ALU and byte-addressed data memory.
// Build option: MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic              req_load,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              addr_err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [2:0]        LAT_INIT  = 3'(RD_LAT);
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_e            state_q, state_d;
  op_e               op_q;
  size_e             size_q;
  logic              uns_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [2:0]        cnt_q;
  logic [31:0]       wb_data_q;
  logic              wen_q;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  // Request decode, evaluated against the live request in IDLE.
  logic              accept;
  op_e               req_op;
  size_e             req_sz;
  logic [1:0]        off_eff;
  logic              misalign;
  logic [ADDR_W:0]   end_addr;
  logic              range_err;
  logic              fault;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_be;
  logic [31:0]       ext_data;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign req_sz = norm_size(req_size);
  assign req_op = req_store ? OP_STORE : (req_load ? OP_LOAD : OP_NONE);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misalign = ((req_sz == SZ_HALF) && req_addr[0]) ||
                    ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign off_eff  = req_addr[1:0];
`else
  assign misalign = 1'b0;
  assign off_eff  = (req_sz == SZ_WORD) ? 2'b00 :
                    (req_sz == SZ_HALF) ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif

  // The range check uses the raw address so a forced-down alignment cannot hide an overrun.
  assign end_addr  = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, size_bytes(req_sz)};
  assign range_err = end_addr > MEM_LIMIT;
  assign fault     = (req_op != OP_NONE) && (range_err || misalign);

  always_comb begin
    lane_wdata = req_wdata;
    lane_be    = BE_WORD;
    case (req_sz)
      SZ_BYTE: begin
        lane_wdata = {4{req_wdata[7:0]}};
        lane_be    = BE_BYTE >> off_eff;
      end
      SZ_HALF: begin
        lane_wdata = {2{req_wdata[15:0]}};
        lane_be    = BE_HALF >> off_eff;
      end
      default: begin
        lane_wdata = req_wdata;
        lane_be    = BE_WORD;
      end
    endcase
  end

  load_extract u_load_extract (
    .rdata_i    (dm_rdata),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((req_op == OP_NONE) || fault) state_d = ST_RESP;
          else                              state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = (op_q == OP_LOAD) ? ST_WAIT : ST_RESP;
      ST_WAIT:   if (cnt_q == 3'd1) state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NONE;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cnt_q      <= '0;
      wb_data_q  <= '0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            size_q    <= req_sz;
            uns_q     <= req_unsigned;
            rd_q      <= req_rd;
            addr_q    <= {req_addr[ADDR_W-1:2], off_eff};
            wdata_q   <= lane_wdata;
            be_q      <= lane_be;
            wb_data_q <= '0;
            wen_q     <= (req_op == OP_LOAD) && !fault;
            err_q     <= fault;
            if (fault) err_addr_q <= req_addr;
          end
        end
        ST_ACCESS: cnt_q <= LAT_INIT;
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) wb_data_q <= ext_data;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from the state register, so reset clears strobes at once.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    dm_we     = (state_q == ST_ACCESS) && (op_q == OP_STORE);
    dm_re     = (state_q == ST_ACCESS) && (op_q == OP_LOAD);
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_be     = '0;
    if (state_q == ST_ACCESS) dm_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (dm_we) begin
      dm_wdata = wdata_q;
      dm_be    = be_q;
    end
    if (dm_re) dm_be = BE_WORD;
    wb_valid = (state_q == ST_RESP);
    wb_wen   = wb_valid && wen_q;
    wb_rd    = wb_valid ? rd_q : 5'd0;
    wb_data  = wb_valid ? wb_data_q : 32'd0;
    addr_err = wb_valid && err_q;
    err_addr = err_addr_q;
  end

endmodule
